reg_alu_pipe: RTL and testbench

REG_ALU_PIPE -- requirements
Module: reg_alu_pipe

---
 rtl/reg_alu_pkg.sv | 18 +
 rtl/reg_alu_pipe_if.sv | 33 +++
 rtl/reg_alu_pipe_alu.sv | 55 +++++
 rtl/reg_alu_pipe.sv | 115 +++++++++++
 tb/tb_reg_alu_pipe.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_alu_pkg.sv
// Shared constants for the register-file ALU pipeline: op encodings and width defaults.
package reg_alu_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 3;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_ADC = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } op_t;

endpackage

// File: rtl/reg_alu_pipe_if.sv
// Instruction and result handshake bundle between an issuer (master) and reg_alu_pipe (slave).
interface reg_alu_pipe_if import reg_alu_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              in_valid;
    logic              in_ready;
    logic              sel;
    logic [2:0]        op;
    logic              wr_en;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] d_in;
    logic [DATA_W-1:0] d_out_a;
    logic [DATA_W-1:0] d_out_b;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic              res_ready;
    logic              cout;
    logic              zero;

    modport master (
        output in_valid, sel, op, wr_en, rd_addr_a, rd_addr_b, wr_addr, d_in, res_ready,
        input  in_ready, d_out_a, d_out_b, res_valid, res_data, cout, zero
    );

    modport slave (
        input  in_valid, sel, op, wr_en, rd_addr_a, rd_addr_b, wr_addr, d_in, res_ready,
        output in_ready, d_out_a, d_out_b, res_valid, res_data, cout, zero
    );

endinterface

// File: rtl/reg_alu_pipe_alu.sv
// Combinational ALU: DATA_W-bit result plus carry taken from bit DATA_W of the widened sum.
module alu_core_p import reg_alu_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF
) (
    input  op_t               op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    output logic [DATA_W-1:0] y,
    output logic              co
);
    localparam logic [DATA_W:0] ONE = {{DATA_W{1'b0}}, 1'b1};

    logic [DATA_W:0] sum;

    always_comb begin
        sum = '0;
        y   = '0;
        co  = 1'b0;
        case (op)
            OP_ADD: begin
                sum = {1'b0, a} + {1'b0, b};
                y   = sum[DATA_W-1:0];
                co  = sum[DATA_W];
            end
            // carry out of a + ~b + 1 is the inverted borrow
            OP_SUB: begin
                sum = {1'b0, a} + {1'b0, ~b} + ONE;
                y   = sum[DATA_W-1:0];
                co  = sum[DATA_W];
            end
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_ADC: begin
                sum = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
                y   = sum[DATA_W-1:0];
                co  = sum[DATA_W];
            end
            OP_SHL: begin
                y  = {a[DATA_W-2:0], 1'b0};
                co = a[DATA_W-1];
            end
            OP_SHR: begin
                y  = {1'b0, a[DATA_W-1:1]};
                co = a[0];
            end
            default: begin
                y  = '0;
                co = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/reg_alu_pipe.sv
// Two-stage register-file ALU: read/accept into EX, then execute and write back with
// same-edge forwarding and a result handshake that back-pressures the whole pipe.
module reg_alu_pipe import reg_alu_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input logic           clk,
    input logic           reset,
    reg_alu_pipe_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];

    logic              vld_p1;
    op_t               op_p1;
    logic              sel_p1;
    logic              wr_en_p1;
    logic [ADDR_W-1:0] wr_addr_p1;
    logic [DATA_W-1:0] d_in_p1;
    logic [DATA_W-1:0] a_p1;
    logic [DATA_W-1:0] b_p1;

    logic              vld_p2;
    logic [DATA_W-1:0] res_data_p2;
    logic              cout_p2;
    logic              zero_p2;

    logic              stall;
    logic              accept;
    logic              advance;
    logic              fwd_a;
    logic              fwd_b;
    logic [DATA_W-1:0] alu_y;
    logic              alu_co;
    logic [DATA_W-1:0] result;

    assign stall   = vld_p2 && !bus.res_ready;
    assign accept  = bus.in_valid && !stall;
    assign advance = vld_p1 && !stall;

    alu_core_p #(.DATA_W(DATA_W)) u_alu (
        .op  (op_p1),
        .a   (a_p1),
        .b   (b_p1),
        .cin (cout_p2),
        .y   (alu_y),
        .co  (alu_co)
    );

    assign result = sel_p1 ? alu_y : d_in_p1;

    // An operand whose source is being written on this same edge takes the EX result.
    assign fwd_a = advance && wr_en_p1 && (bus.rd_addr_a == wr_addr_p1);
    assign fwd_b = advance && wr_en_p1 && (bus.rd_addr_b == wr_addr_p1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (advance && wr_en_p1) begin
            regs[wr_addr_p1] <= result;
        end
    end

    // p0 -> p1: accept and read operands into EX
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1     <= 1'b0;
            op_p1      <= OP_ADD;
            sel_p1     <= 1'b0;
            wr_en_p1   <= 1'b0;
            wr_addr_p1 <= '0;
            d_in_p1    <= '0;
            a_p1       <= '0;
            b_p1       <= '0;
        end else if (accept) begin
            vld_p1     <= 1'b1;
            op_p1      <= op_t'(bus.op);
            sel_p1     <= bus.sel;
            wr_en_p1   <= bus.wr_en;
            wr_addr_p1 <= bus.wr_addr;
            d_in_p1    <= bus.d_in;
            a_p1       <= fwd_a ? result : regs[bus.rd_addr_a];
            b_p1       <= fwd_b ? result : regs[bus.rd_addr_b];
        end else if (advance) begin
            vld_p1     <= 1'b0;
        end
    end

    // p1 -> p2: execute, register result and flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p2      <= 1'b0;
            res_data_p2 <= '0;
            cout_p2     <= 1'b0;
            zero_p2     <= 1'b0;
        end else if (advance) begin
            vld_p2      <= 1'b1;
            res_data_p2 <= result;
            zero_p2     <= (result == '0);
            if (sel_p1) cout_p2 <= alu_co;
        end else if (bus.res_ready) begin
            vld_p2      <= 1'b0;
        end
    end

    assign bus.in_ready  = !stall;
    assign bus.d_out_a   = a_p1;
    assign bus.d_out_b   = b_p1;
    assign bus.res_valid = vld_p2;
    assign bus.res_data  = res_data_p2;
    assign bus.cout      = cout_p2;
    assign bus.zero      = zero_p2;

endmodule

// File: tb/tb_reg_alu_pipe.sv
// Scoreboard bench for reg_alu_pipe: a sequential instruction-level model predicts every result.
module tb_reg_alu_pipe;
    import reg_alu_pkg::*;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    reg_alu_pipe_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    reg_alu_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] data;
        logic       cout;
        logic       zero;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_regs[8];
    int   m_cout = 0;
    int   rr_mode = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Architectural model: instructions complete in program order.
    task automatic model(input logic s, input logic [2:0] o, input logic we,
                         input int ra, input int rb, input int wa, input int din);
        int a, b, y, c, t;
        exp_t e;
        a = m_regs[ra];
        b = m_regs[rb];
        c = m_cout;
        y = din;
        if (s) begin
            case (o)
                3'd0: begin t = a + b; y = t % 256; c = t / 256; end
                3'd1: begin y = (a - b + 256) % 256; c = (a >= b) ? 1 : 0; end
                3'd2: begin y = a & b; c = 0; end
                3'd3: begin y = a | b; c = 0; end
                3'd4: begin y = a ^ b; c = 0; end
                3'd5: begin t = a + b + m_cout; y = t % 256; c = t / 256; end
                3'd6: begin y = (a * 2) % 256; c = a / 128; end
                default: begin y = a / 2; c = a % 2; end
            endcase
        end
        if (we) m_regs[wa] = y;
        m_cout = c;
        e.data = 8'(y);
        e.cout = (c != 0);
        e.zero = (y == 0);
        sb_q.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input logic s, input logic [2:0] o, input logic we,
                         input int ra, input int rb, input int wa, input int din);
        int waited = 0;
        bus.in_valid  = 1'b1;
        bus.sel       = s;
        bus.op        = o;
        bus.wr_en     = we;
        bus.rd_addr_a = 3'(ra);
        bus.rd_addr_b = 3'(rb);
        bus.wr_addr   = 3'(wa);
        bus.d_in      = 8'(din);
        @(negedge clk);
        while (!bus.in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            check("accept_timeout", 32'(bus.in_ready), 1);
            bus.in_valid = 1'b0;
            @(posedge clk);
        end else begin
            @(posedge clk);
            model(s, o, we, ra, rb, wa, din);
        end
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while ((sb_q.size() != 0 || bus.res_valid) && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("drain_queue", sb_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) m_regs[i] = 0;
        m_cout = 0;
    endtask

    initial begin
        bus.res_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rr_mode)
                0: bus.res_ready = 1'b1;
                1: bus.res_ready = ($urandom_range(0, 3) != 0);
                default: bus.res_ready = 1'b0;
            endcase
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && bus.res_valid && bus.res_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_result", 32'(bus.res_valid), 0);
                end else begin
                    e = sb_q.pop_front();
                    check("res_data", 32'(bus.res_data), 32'(e.data));
                    check("cout", 32'(bus.cout), 32'(e.cout));
                    check("zero", 32'(bus.zero), 32'(e.zero));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.sel       = 1'b0;
        bus.op        = 3'd0;
        bus.wr_en     = 1'b0;
        bus.rd_addr_a = '0;
        bus.rd_addr_b = '0;
        bus.wr_addr   = '0;
        bus.d_in      = '0;
        clear_model();
        reset = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 1);
        check("rst_res_valid", 32'(bus.res_valid), 0);
        check("rst_res_data", 32'(bus.res_data), 0);
        check("rst_d_out_a", 32'(bus.d_out_a), 0);
        check("rst_d_out_b", 32'(bus.d_out_b), 0);
        check("rst_cout", 32'(bus.cout), 0);
        check("rst_zero", 32'(bus.zero), 0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;

        // Loads then ADD 0x0F + 0xF1 with latency and operand checks
        issue(1'b0, 3'd0, 1'b1, 0, 0, 1, 8'h0F);
        issue(1'b0, 3'd0, 1'b1, 0, 0, 2, 8'hF1);
        idle();
        drain();
        issue(1'b1, 3'd0, 1'b1, 1, 2, 3, 0);
        idle();
        @(negedge clk);
        check("lat_not_yet", 32'(bus.res_valid), 0);
        check("d_out_a", 32'(bus.d_out_a), 8'h0F);
        check("d_out_b", 32'(bus.d_out_b), 8'hF1);
        @(negedge clk);
        check("lat_valid", 32'(bus.res_valid), 1);
        @(posedge clk);
        #1;
        drain();

        // Back-to-back forwarding: load r1 then ADD r1,r1->r2, then read r2
        issue(1'b0, 3'd0, 1'b1, 0, 0, 1, 8'h05);
        issue(1'b1, 3'd0, 1'b1, 1, 1, 2, 0);
        issue(1'b1, 3'd0, 1'b1, 2, 0, 4, 0);
        idle();
        drain();

        // Carry chain: ADD 0xFF+0x01 then ADC 0+0
        issue(1'b0, 3'd0, 1'b1, 0, 0, 5, 8'hFF);
        issue(1'b0, 3'd0, 1'b1, 0, 0, 6, 8'h01);
        issue(1'b1, 3'd0, 1'b1, 5, 6, 7, 0);
        issue(1'b1, 3'd5, 1'b1, 0, 0, 7, 0);
        // SUB with borrow, SHR, XOR to zero
        issue(1'b0, 3'd0, 1'b1, 0, 0, 1, 8'h03);
        issue(1'b0, 3'd0, 1'b1, 0, 0, 2, 8'h05);
        issue(1'b1, 3'd1, 1'b1, 1, 2, 3, 0);
        issue(1'b0, 3'd0, 1'b1, 0, 0, 4, 8'h81);
        issue(1'b1, 3'd7, 1'b1, 4, 0, 5, 0);
        issue(1'b0, 3'd0, 1'b1, 0, 0, 6, 8'hAA);
        issue(1'b1, 3'd4, 1'b1, 6, 6, 7, 0);
        issue(1'b1, 3'd6, 1'b0, 6, 0, 1, 0);
        issue(1'b1, 3'd0, 1'b1, 1, 0, 2, 0);
        idle();
        drain();

        // Stall: result held while a second instruction waits in EX
        rr_mode = 2;
        @(posedge clk);
        #1;
        issue(1'b0, 3'd0, 1'b1, 0, 0, 4, 8'h33);
        issue(1'b1, 3'd0, 1'b1, 4, 4, 4, 0);
        bus.in_valid  = 1'b1;
        bus.sel       = 1'b1;
        bus.op        = 3'd0;
        bus.wr_en     = 1'b1;
        bus.rd_addr_a = 3'd4;
        bus.rd_addr_b = 3'd4;
        bus.wr_addr   = 3'd5;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(bus.in_ready), 0);
            check("stall_res_valid", 32'(bus.res_valid), 1);
            check("stall_res_data", 32'(bus.res_data), 8'h33);
        end
        @(posedge clk);
        #1 rr_mode = 0;
        issue(1'b1, 3'd0, 1'b1, 4, 4, 5, 0);
        issue(1'b1, 3'd0, 1'b1, 5, 0, 6, 0);
        idle();
        drain();

        // Randomized traffic with random back-pressure
        rr_mode = 1;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                idle();
                @(posedge clk);
                #1;
            end else begin
                issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                      1'($urandom_range(0, 3) != 0),
                      $urandom_range(0, 7), $urandom_range(0, 7),
                      $urandom_range(0, 7), $urandom_range(0, 255));
            end
        end
        idle();
        rr_mode = 0;
        drain();

        // Reset with an instruction in EX: discarded, nothing written
        issue(1'b0, 3'd0, 1'b1, 0, 0, 1, 8'hFF);
        issue(1'b1, 3'd0, 1'b1, 1, 1, 0, 0);
        idle();
        drain();
        issue(1'b0, 3'd0, 1'b1, 0, 0, 3, 8'h77);
        idle();
        reset = 1'b0;
        sb_q.delete();
        clear_model();
        @(negedge clk);
        check("rst_mid_res_valid", 32'(bus.res_valid), 0);
        check("rst_mid_cout", 32'(bus.cout), 0);
        check("rst_mid_zero", 32'(bus.zero), 0);
        check("rst_mid_in_ready", 32'(bus.in_ready), 1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("post_rst_res_valid", 32'(bus.res_valid), 0);
        @(posedge clk);
        #1;
        issue(1'b1, 3'd0, 1'b1, 3, 1, 2, 0);
        issue(1'b1, 3'd5, 1'b1, 0, 0, 4, 0);
        idle();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
